// File: rtl/mux_rr_arbiter_if.sv
// Bundle of the requester-side and sink-side stream signals shared by the
// round-robin packet arbiter. The master side drives requests and downstream ready.
interface mux_rr_arbiter_if #(
  parameter int N     = 2,
  parameter int W     = 8,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_last;
  logic [N-1:0]     req_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_last;
  logic             out_ready;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] sel;
  logic             busy;

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last, grant, sel, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last, grant, sel, busy
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin packet arbiter: locks one requester onto the shared output channel
// for a whole packet and steers the mux select and ready gating to match.
module mux_rr_arbiter #(
  parameter int N     = 2,
  parameter int W     = 8,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_rr_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] cur_q, cur_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [SEL_W-1:0] pick;
  logic             found;
  logic [W-1:0]     lane [N];

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign lane[i] = bus.req_data[i*W +: W];
  end

  function automatic logic [SEL_W-1:0] rr_index(input logic [SEL_W-1:0] base,
                                                input int unsigned k);
    int unsigned s;
    s = (32'(base) + k) % N;
    return SEL_W'(s);
  endfunction

  // First valid requester after the most recent grant, wrapping modulo N.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      if (!found && bus.req_valid[rr_index(last_q, k)]) begin
        found = 1'b1;
        pick  = rr_index(last_q, k);
      end
    end
  end

  assign bus.sel      = cur_q;
  assign bus.out_data = lane[cur_q];

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    last_d        = last_q;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.req_ready = '0;
    bus.grant     = '0;
    bus.busy      = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          cur_d   = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        bus.busy             = 1'b1;
        bus.grant[cur_q]     = 1'b1;
        bus.out_valid        = bus.req_valid[cur_q];
        bus.out_last         = bus.req_last[cur_q];
        bus.req_ready[cur_q] = bus.out_ready;
        // Only an accepted last beat releases the grant; a valid gap keeps it.
        if (bus.req_valid[cur_q] && bus.out_ready && bus.req_last[cur_q]) begin
          state_d = IDLE;
          last_d  = cur_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      last_q  <= SEL_W'(N - 1);
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scenario bench for mux_rr_arbiter: directed packet scenarios on N=2 and N=4
// instances plus a randomized run against a packet-level round-robin model.
module tb_mux_rr_arbiter;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  logic [8:0] rq [4][$];

  mux_rr_arbiter_if #(.N(2), .W(8)) if2 ();
  mux_rr_arbiter_if #(.N(4), .W(8)) if4 ();

  mux_rr_arbiter #(.N(2), .W(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  mux_rr_arbiter #(.N(4), .W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    if2.req_valid = '0; if2.req_data = '0; if2.req_last = '0; if2.out_ready = 1'b1;
    if4.req_valid = '0; if4.req_data = '0; if4.req_last = '0; if4.out_ready = 1'b1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (if2.grant !== 2'b00) begin failures++; $display("FAIL reset_grant: got %b expected 00", if2.grant); end
      checks++; if (if2.sel !== 1'b0) begin failures++; $display("FAIL reset_sel: got %b expected 0", if2.sel); end
      checks++; if (if2.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", if2.busy); end
      checks++; if (if2.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", if2.out_valid); end
      checks++; if (if2.req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready: got %b expected 00", if2.req_ready); end
      checks++; if (if4.busy !== 1'b0) begin failures++; $display("FAIL reset_busy4: got %b expected 0", if4.busy); end
    end
  endtask

  task automatic test_rotation();
    logic [7:0] exp_seq [4];
    int beats = 0;
    int cyc = 0;
    int last_cyc = -1;
    exp_seq = '{8'hA0, 8'hB1, 8'hA0, 8'hB1};
    apply_reset();
    if2.req_valid = 2'b11;
    if2.req_data  = {8'hB1, 8'hA0};
    if2.req_last  = 2'b11;
    if2.out_ready = 1'b1;
    while (beats < 4 && cyc < 40) begin
      @(negedge clk);
      if (if2.out_valid && if2.out_ready) begin
        checks++;
        if (if2.out_data !== exp_seq[beats]) begin
          failures++; $display("FAIL rotation_data[%0d]: got %h expected %h", beats, if2.out_data, exp_seq[beats]);
        end
        if (last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc !== 2) begin
            failures++; $display("FAIL rotation_gap[%0d]: got %0d cycles expected 2", beats, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        beats++;
      end
      next_cycle();
      cyc++;
    end
    checks++;
    if (beats != 4) begin failures++; $display("FAIL rotation_timeout: got %0d beats expected 4", beats); end
  endtask

  task automatic test_packet_lock();
    logic [7:0] b [3];
    logic [2:0] lst;
    int  p0 = 0;
    int  acc = -1;
    int  cyc = 0;
    bit  gap_done = 1'b0;
    bit  done = 1'b0;
    logic v0;
    b   = '{8'h11, 8'h22, 8'h33};
    lst = 3'b100;
    apply_reset();
    if2.req_valid[1] = 1'b1; if2.req_data[15:8] = 8'h55; if2.req_last[1] = 1'b1;
    while (!done && cyc < 40) begin
      if (p0 < 3 && !(p0 == 2 && !gap_done)) begin
        v0 = 1'b1; if2.req_data[7:0] = b[p0]; if2.req_last[0] = lst[p0];
      end else begin
        v0 = 1'b0; if2.req_last[0] = 1'b0;
        if (p0 == 2) gap_done = 1'b1;
      end
      if2.req_valid[0] = v0;
      @(negedge clk);
      if (acc < 0 && cyc >= 1) begin
        checks++; if (if2.grant !== 2'b01) begin failures++; $display("FAIL lock_grant@%0d: got %b expected 01", cyc, if2.grant); end
        checks++; if (if2.req_ready[1] !== 1'b0) begin failures++; $display("FAIL lock_ready1@%0d: got %b expected 0", cyc, if2.req_ready[1]); end
      end
      if (v0 && if2.req_ready[0]) begin
        checks++;
        if (if2.out_data !== b[p0]) begin failures++; $display("FAIL lock_data[%0d]: got %h expected %h", p0, if2.out_data, b[p0]); end
        if (p0 == 2) acc = cyc;
        p0++;
      end else if (acc >= 0 && cyc == acc + 1) begin
        checks++; if (if2.grant !== 2'b00) begin failures++; $display("FAIL lock_bubble: got %b expected 00", if2.grant); end
      end else if (acc >= 0 && cyc == acc + 2) begin
        checks++; if (if2.grant !== 2'b10) begin failures++; $display("FAIL lock_next_grant: got %b expected 10", if2.grant); end
        done = 1'b1;
      end
      next_cycle();
      cyc++;
    end
    checks++;
    if (!done) begin failures++; $display("FAIL lock_timeout: got %0d beats expected 3", p0); end
  endtask

  task automatic test_backpressure();
    logic [7:0] b [3];
    logic [7:0] got [$];
    logic [2:0] lst;
    int p0 = 0;
    int cyc = 0;
    b   = '{8'h61, 8'h62, 8'h63};
    lst = 3'b100;
    apply_reset();
    while (p0 < 3 && cyc < 30) begin
      if2.req_valid[0] = 1'b1;
      if2.req_data[7:0] = b[p0];
      if2.req_last[0] = lst[p0];
      if2.out_ready = (cyc >= 2 && cyc <= 5) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (cyc >= 2 && cyc <= 5) begin
        checks++; if (if2.out_data !== b[p0]) begin failures++; $display("FAIL bp_data@%0d: got %h expected %h", cyc, if2.out_data, b[p0]); end
        checks++; if (if2.req_ready[0] !== 1'b0) begin failures++; $display("FAIL bp_ready@%0d: got %b expected 0", cyc, if2.req_ready[0]); end
        checks++; if (if2.out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid@%0d: got %b expected 1", cyc, if2.out_valid); end
      end
      if (if2.req_ready[0]) begin
        got.push_back(if2.out_data);
        p0++;
      end
      next_cycle();
      cyc++;
    end
    if2.req_valid = '0;
    checks++;
    if (got.size() != 3) begin failures++; $display("FAIL bp_count: got %0d beats expected 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== b[i]) begin failures++; $display("FAIL bp_beat[%0d]: got %h expected %h", i, got[i], b[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b1 [4];
    int p0 = 0;
    int p1 = 0;
    int cyc = 0;
    bit done = 1'b0;
    logic v0, v1;
    b1 = '{8'h81, 8'h82, 8'h83, 8'h84};
    apply_reset();
    while (!done && cyc < 40) begin
      v0 = (p0 < 1);
      v1 = (p1 < 4);
      if2.req_valid = {v1, v0};
      if2.req_data  = {(p1 < 4) ? b1[p1] : 8'h00, 8'h70};
      if2.req_last  = {(p1 == 3), 1'b1};
      @(negedge clk);
      if (p1 == 1) begin
        checks++; if (if2.grant !== 2'b10) begin failures++; $display("FAIL rstmid_pre_grant: got %b expected 10", if2.grant); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (if2.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", if2.busy); end
        checks++; if (if2.grant !== 2'b00) begin failures++; $display("FAIL rstmid_grant: got %b expected 00", if2.grant); end
        checks++; if (if2.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid: got %b expected 0", if2.out_valid); end
        checks++; if (if2.req_ready !== 2'b00) begin failures++; $display("FAIL rstmid_ready: got %b expected 00", if2.req_ready); end
        done = 1'b1;
      end else begin
        if (v0 && if2.req_ready[0]) p0++;
        if (v1 && if2.req_ready[1]) p1++;
        next_cycle();
      end
      cyc++;
    end
    checks++;
    if (!done) begin failures++; $display("FAIL rstmid_timeout: got %0d beats of requester 1 expected 1", p1); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    if2.req_valid = 2'b11;
    if2.req_data  = {8'h81, 8'h70};
    if2.req_last  = 2'b01;
    @(negedge clk);
    checks++; if (if2.grant !== 2'b00) begin failures++; $display("FAIL rstmid_arb_cycle: got %b expected 00", if2.grant); end
    next_cycle();
    @(negedge clk);
    checks++; if (if2.grant !== 2'b01) begin failures++; $display("FAIL rstmid_priority: got %b expected 01", if2.grant); end
    checks++; if (if2.out_data !== 8'h70) begin failures++; $display("FAIL rstmid_data: got %h expected 70", if2.out_data); end
    clear_inputs();
  endtask

  task automatic test_wraparound();
    int n = 0;
    int cyc = 0;
    logic [3:0] exp_g;
    apply_reset();
    if4.req_valid = 4'hF;
    if4.req_data  = {8'h03, 8'h02, 8'h01, 8'h00};
    if4.req_last  = 4'hF;
    while (n < 5 && cyc < 60) begin
      @(negedge clk);
      if (if4.grant !== 4'b0000) begin
        exp_g = 4'b0001 << (n % 4);
        checks++; if (if4.grant !== exp_g) begin failures++; $display("FAIL wrap_grant[%0d]: got %b expected %b", n, if4.grant, exp_g); end
        checks++; if (if4.out_data !== 8'(n % 4)) begin failures++; $display("FAIL wrap_data[%0d]: got %h expected %h", n, if4.out_data, 8'(n % 4)); end
        n++;
      end
      next_cycle();
      cyc++;
    end
    checks++;
    if (n != 5) begin failures++; $display("FAIL wrap_timeout: got %0d grants expected 5", n); end
    clear_inputs();
  endtask

  task automatic test_random();
    int owner = -1;
    int ptr = 3;
    int cyc = 0;
    int len, npk, idx;
    logic [1:0] exp_sel = 2'd0;
    logic [3:0] v, exp_grant, exp_ready;
    logic rdy, exp_busy, exp_valid, pending;
    logic [8:0] beat;
    for (int i = 0; i < 4; i++) begin
      rq[i].delete();
      npk = $urandom_range(1, 3);
      for (int p = 0; p < npk; p++) begin
        len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++) rq[i].push_back({1'(k == len - 1), 8'($urandom)});
      end
    end
    apply_reset();
    pending = 1'b1;
    while (pending && cyc < 4000) begin
      for (int i = 0; i < 4; i++) begin
        v[i] = (rq[i].size() > 0) && ($urandom_range(0, 3) != 0);
        if (v[i]) begin
          if4.req_data[i*8 +: 8] = rq[i][0][7:0]; if4.req_last[i] = rq[i][0][8];
        end else begin
          if4.req_data[i*8 +: 8] = 8'($urandom); if4.req_last[i] = 1'b0;
        end
      end
      if4.req_valid = v;
      rdy = ($urandom_range(0, 3) != 0);
      if4.out_ready = rdy;
      @(negedge clk);
      if (owner < 0) begin
        exp_grant = 4'b0; exp_busy = 1'b0; exp_valid = 1'b0; exp_ready = 4'b0;
      end else begin
        exp_grant = 4'b0001 << owner; exp_busy = 1'b1; exp_valid = v[owner];
        exp_ready = rdy ? exp_grant : 4'b0;
      end
      checks++; if (if4.grant !== exp_grant) begin failures++; $display("FAIL rnd_grant@%0d: got %b expected %b", cyc, if4.grant, exp_grant); end
      checks++; if (if4.busy !== exp_busy) begin failures++; $display("FAIL rnd_busy@%0d: got %b expected %b", cyc, if4.busy, exp_busy); end
      checks++; if (if4.out_valid !== exp_valid) begin failures++; $display("FAIL rnd_valid@%0d: got %b expected %b", cyc, if4.out_valid, exp_valid); end
      checks++; if (if4.req_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready@%0d: got %b expected %b", cyc, if4.req_ready, exp_ready); end
      checks++; if (if4.sel !== exp_sel) begin failures++; $display("FAIL rnd_sel@%0d: got %0d expected %0d", cyc, if4.sel, exp_sel); end
      if (exp_valid) begin
        checks++; if (if4.out_data !== rq[owner][0][7:0]) begin failures++; $display("FAIL rnd_data@%0d: got %h expected %h", cyc, if4.out_data, rq[owner][0][7:0]); end
        checks++; if (if4.out_last !== rq[owner][0][8]) begin failures++; $display("FAIL rnd_last@%0d: got %b expected %b", cyc, if4.out_last, rq[owner][0][8]); end
      end
      if (owner < 0) begin
        for (int k = 1; k <= 4; k++) begin
          idx = (ptr + k) % 4;
          if (owner < 0 && v[idx]) begin owner = idx; exp_sel = 2'(idx); end
        end
      end else if (v[owner] && rdy) begin
        beat = rq[owner].pop_front();
        if (beat[8]) begin ptr = owner; owner = -1; end
      end
      pending = (owner >= 0);
      for (int i = 0; i < 4; i++) if (rq[i].size() > 0) pending = 1'b1;
      next_cycle();
      cyc++;
    end
    checks++;
    if (pending) begin failures++; $display("FAIL rnd_drain: got pending traffic after %0d cycles expected drained", cyc); end
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_rotation();
    test_packet_lock();
    test_backpressure();
    test_reset_mid();
    test_wraparound();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
